module_display_scan_ctrl: RTL and testbench
===========================================

MODULE_DISPLAY_SCAN_CTRL -- requirements
Module: module_display_scan_ctrl

Interface
REQ-001 Parameter N_DIGITS, default 8, number of multiplexed 7-segment digits.
REQ-002 Parameter TICK_DIV, default 10_000, clock cycles each digit is driven (1 kHz per digit at 10 MHz); SHALL be >= 2.
REQ-003 Parameter GUARD_CYCLES, default 16, all-anodes-off dead time before each digit (anti-ghosting); SHALL be >= 1.
REQ-004 clk_10Mhz_i  in  1  sole clock, all logic on rising edge.
REQ-005 reset_i  in  1  asynchronous active-low reset.
REQ-006 data_i  in  4*N_DIGITS  hex nibble per digit, digit k = bits [4k+3:4k].
REQ-007 dp_i  in  N_DIGITS  decimal point per digit, 1 = lit.
REQ-008 en_mask_i  in  N_DIGITS  digit enable, 1 = digit participates in scan.
REQ-009 load_i  in  1  single-cycle request to capture data_i/dp_i/en_mask_i.
REQ-010 load_ack_o  out  1  one-cycle pulse when captured values become displayed.
REQ-011 frame_done_o  out  1  one-cycle pulse at end of each full scan frame.
REQ-012 an_o  out  N_DIGITS  anode select, active-low.
REQ-013 seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-014 dp_o  out  1  decimal point, active-low.

Function
REQ-015 Two-state FSM: GUARD, DRIVE; digit index idx in 0..N_DIGITS-1.
REQ-016 GUARD: an_o all ones, seg_o 7'h7F, dp_o 1; lasts exactly GUARD_CYCLES cycles, then DRIVE.
REQ-017 DRIVE: prescaler counts 0..TICK_DIV-1 starting at 0 on entry; state lasts exactly TICK_DIV cycles, then GUARD with idx+1, wrapping N_DIGITS-1 -> 0.
REQ-018 DRIVE with shadow mask bit idx = 1: an_o has only bit idx low; seg_o = hex decode of shadow nibble idx; dp_o = ~shadow dp bit idx.
REQ-019 DRIVE with shadow mask bit idx = 0: an_o, seg_o, dp_o as in GUARD; slot timing unchanged.
REQ-020 Frame period = N_DIGITS*(TICK_DIV+GUARD_CYCLES) cycles.
REQ-021 Frame boundary = DRIVE->GUARD transition at idx N_DIGITS-1; frame_done_o pulses on that cycle.
REQ-022 load_i = 1 writes data_i/dp_i/en_mask_i into a staging register and sets pending.
REQ-023 load_i while pending overwrites staging; only one acknowledge issued.
REQ-024 At a frame boundary with pending = 1: staging -> shadow, load_ack_o pulses same cycle as frame_done_o, pending clears.
REQ-025 load_i on a frame-boundary cycle: shadow takes the pre-cycle staging value only if pending was already 1; the new value is staged and pending = 1 afterwards.
REQ-026 Shadow never changes mid-frame (no tearing); new data visible on digit 0 GUARD_CYCLES+1 cycles after load_ack_o.
REQ-027 Hex decode covers 0-F, standard glyphs (b, d lowercase).

Reset
REQ-028 reset_i = 0 immediately forces: GUARD, guard counter 0, idx 0, prescaler 0, pending 0, staging and shadow all zero (mask 0), an_o all ones, seg_o 7'h7F, dp_o 1, load_ack_o 0, frame_done_o 0.
REQ-029 Reset mid-frame or mid-pending discards staged data, no acknowledge; first DRIVE begins GUARD_CYCLES cycles after release.

Configuration
REQ-030 Macro LEADING_ZERO_BLANK_EN defined: digit k > 0 SHALL be blanked (segments and dp off, anode off) when its nibble and all higher enabled nibbles are 0 and their dp bits are 0; digit 0 never blanked.
REQ-031 Macro undefined: every enabled digit displays its nibble, no blanking logic synthesized.

Structure
REQ-032 Package display_pkg holds: state enum (GUARD, DRIVE), 7-bit segment constants for 0-F, SEG_BLANK = 7'h7F.
REQ-033 One sub-module module_hex_to_seg: 4-bit nibble -> 7-bit active-low segments, combinational.

Verification (TICK_DIV=4, GUARD_CYCLES=2, N_DIGITS=8)
REQ-034 Hold reset_i=0 -> an_o=8'hFF, seg_o=7'h7F, pulses 0; release -> 2 cycles GUARD, then scan starts; mask 0 keeps an_o=8'hFF.
REQ-035 Load 32'h7654_3210, mask 8'hFF -> after ack an_o sequence FE,FD,...,7F each 4 cycles with 2-cycle FF gaps; digit 3 seg_o=7'b0110000, digit 0 seg_o=7'b1000000.
REQ-036 load_i pulse mid-frame with 32'h0000_00AB -> display unchanged until frame_done_o; load_ack_o coincident; next digit 0 seg_o=7'b0000011.
REQ-037 load_i on frame-boundary cycle with pending=0 -> no ack that frame; ack and update exactly one frame (48 cycles) later.
REQ-038 en_mask 8'h05 -> an_o low only in slots 0 (FE) and 2 (FB); other slots an_o=FF, frame period still 48 cycles.
REQ-039 LEADING_ZERO_BLANK_EN, data 32'h0000_0120, mask FF -> digits 7..3 blank, digits 2..0 show 1,2,0; data 0 -> only digit 0 shows 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment display scanner:
// scan FSM states and active-low segment glyphs ({g,f,e,d,c,b,a}, 0 = lit).
package display_pkg;

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;  // lowercase b
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;  // lowercase d
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/module_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module module_hex_to_seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure lookup: one glyph per nibble value.
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/module_display_scan_ctrl.sv
// Multiplexed 7-segment scan controller. Each digit slot is a GUARD period
// (all anodes off) followed by a DRIVE period. New data is staged on load_i
// and only copied into the displayed (shadow) copy at a frame boundary, so a
// frame is never torn. Optional build macro LEADING_ZERO_BLANK_EN blanks
// leading zero digits above digit 0.
module module_display_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int TICK_DIV     = 10_000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    clk_10Mhz_i,
    input  logic                    reset_i,
    input  logic [4*N_DIGITS-1:0]   data_i,
    input  logic [N_DIGITS-1:0]     dp_i,
    input  logic [N_DIGITS-1:0]     en_mask_i,
    input  logic                    load_i,
    output logic                    load_ack_o,
    output logic                    frame_done_o,
    output logic [N_DIGITS-1:0]     an_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int GRD_W = $clog2(GUARD_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_PENULT = PRE_W'(TICK_DIV - 2);
    localparam logic [GRD_W-1:0] GRD_LAST   = GRD_W'(GUARD_CYCLES - 1);

    scan_state_t            state_reg;
    logic [GRD_W-1:0]       guard_cnt_reg;
    logic [PRE_W-1:0]       pre_reg;
    logic [IDX_W-1:0]       idx_reg;

    logic [4*N_DIGITS-1:0]  stage_data_reg;
    logic [N_DIGITS-1:0]    stage_dp_reg;
    logic [N_DIGITS-1:0]    stage_mask_reg;
    logic                   pending_reg;

    logic [4*N_DIGITS-1:0]  shadow_data_reg;
    logic [N_DIGITS-1:0]    shadow_dp_reg;
    logic [N_DIGITS-1:0]    shadow_mask_reg;

    logic [N_DIGITS-1:0]    an_reg;
    logic [6:0]             seg_reg;
    logic                   dp_reg;
    logic                   load_ack_reg;
    logic                   frame_done_reg;

    logic [3:0]             nib [N_DIGITS];
    logic [3:0]             cur_nib;
    logic [6:0]             cur_seg;
    logic [N_DIGITS-1:0]    blank;
    logic                   lit;

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nib
        assign nib[gi] = shadow_data_reg[4*gi +: 4];
    end

    assign cur_nib = nib[idx_reg];

    module_hex_to_seg u_hex_to_seg (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic lz_run;

    // Walk down from the top digit: a digit is blanked while it and every
    // enabled digit above it is a zero nibble with no decimal point.
    always_comb begin
        blank  = '0;
        lz_run = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            lz_run   = lz_run & (~shadow_mask_reg[k] |
                       ((shadow_data_reg[4*k +: 4] == 4'h0) & ~shadow_dp_reg[k]));
            blank[k] = lz_run;
        end
    end
`else
    assign blank = '0;
`endif

    assign lit = shadow_mask_reg[idx_reg] & ~blank[idx_reg];

    // Scan FSM: slot timing plus registered anode/segment/pulse outputs.
    // The frame/ack pulses are raised one cycle early so they coincide with
    // the last DRIVE cycle of the last digit (the frame boundary).
    always_ff @(posedge clk_10Mhz_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg      <= GUARD;
            guard_cnt_reg  <= '0;
            pre_reg        <= '0;
            idx_reg        <= '0;
            an_reg         <= '1;
            seg_reg        <= SEG_BLANK;
            dp_reg         <= 1'b1;
            load_ack_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            load_ack_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            case (state_reg)
                GUARD: begin
                    if (guard_cnt_reg == GRD_LAST) begin
                        state_reg     <= DRIVE;
                        guard_cnt_reg <= '0;
                        pre_reg       <= '0;
                        if (lit) begin
                            an_reg  <= ~(N_DIGITS'(1) << idx_reg);
                            seg_reg <= cur_seg;
                            dp_reg  <= ~shadow_dp_reg[idx_reg];
                        end
                    end else begin
                        guard_cnt_reg <= guard_cnt_reg + 1'b1;
                    end
                end
                DRIVE: begin
                    if (pre_reg == PRE_LAST) begin
                        state_reg <= GUARD;
                        pre_reg   <= '0;
                        idx_reg   <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
                        an_reg    <= '1;
                        seg_reg   <= SEG_BLANK;
                        dp_reg    <= 1'b1;
                    end else begin
                        pre_reg <= pre_reg + 1'b1;
                        if (idx_reg == LAST_IDX && pre_reg == PRE_PENULT) begin
                            frame_done_reg <= 1'b1;
                            load_ack_reg   <= pending_reg | load_i;
                        end
                    end
                end
                default: state_reg <= GUARD;
            endcase
        end
    end

    // Staging/shadow double buffer: commit at the frame boundary first, then
    // let a same-cycle load re-stage and re-arm pending.
    always_ff @(posedge clk_10Mhz_i or negedge reset_i) begin
        if (!reset_i) begin
            stage_data_reg  <= '0;
            stage_dp_reg    <= '0;
            stage_mask_reg  <= '0;
            pending_reg     <= 1'b0;
            shadow_data_reg <= '0;
            shadow_dp_reg   <= '0;
            shadow_mask_reg <= '0;
        end else begin
            if (frame_done_reg && pending_reg) begin
                shadow_data_reg <= stage_data_reg;
                shadow_dp_reg   <= stage_dp_reg;
                shadow_mask_reg <= stage_mask_reg;
                pending_reg     <= 1'b0;
            end
            if (load_i) begin
                stage_data_reg <= data_i;
                stage_dp_reg   <= dp_i;
                stage_mask_reg <= en_mask_i;
                pending_reg    <= 1'b1;
            end
        end
    end

    assign an_o         = an_reg;
    assign seg_o        = seg_reg;
    assign dp_o         = dp_reg;
    assign load_ack_o   = load_ack_reg;
    assign frame_done_o = frame_done_reg;

endmodule

// File: tb/tb_module_display_scan_ctrl.sv
// Bench for module_display_scan_ctrl (N_DIGITS=8, TICK_DIV=4, GUARD_CYCLES=2).
// A cycle-position reference model checks every cycle; a vector table checks
// glyph/anode/dp values on chosen digits. Honours LEADING_ZERO_BLANK_EN.
module tb_module_display_scan_ctrl;

    localparam int N    = 8;
    localparam int T    = 4;
    localparam int G    = 2;
    localparam int SLOT = T + G;
    localparam int F    = N * SLOT;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] data_i;
    logic [7:0]  dp_i;
    logic [7:0]  en_mask_i;
    logic        load_i;
    logic        load_ack_o;
    logic        frame_done_o;
    logic [7:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;

    always #5 clk = ~clk;

    module_display_scan_ctrl #(
        .N_DIGITS     (N),
        .TICK_DIV     (T),
        .GUARD_CYCLES (G)
    ) dut (
        .clk_10Mhz_i  (clk),
        .reset_i      (reset_i),
        .data_i       (data_i),
        .dp_i         (dp_i),
        .en_mask_i    (en_mask_i),
        .load_i       (load_i),
        .load_ack_o   (load_ack_o),
        .frame_done_o (frame_done_o),
        .an_o         (an_o),
        .seg_o        (seg_o),
        .dp_o         (dp_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (time %0t)", name, act, req, $time);
    endtask

    // ---------------- reference model ----------------
    int unsigned m_t;
    logic        m_pending;
    logic [31:0] m_st_d, m_sh_d;
    logic [7:0]  m_st_dp, m_st_m, m_sh_dp, m_sh_m;

    function automatic logic [6:0] glyph(input int n);
        string segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                             "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                             "cdefg", "adef", "bcdeg", "adefg", "aefg"};
        logic [6:0] v = 7'h7F;
        string s = segs[n];
        for (int i = 0; i < s.len(); i++) v[int'(s[i]) - 97] = 1'b0;
        return v;
    endfunction

    function automatic bit blanked(input int k);
        if (!LZB || k == 0) return 1'b0;
        for (int j = k; j < N; j++)
            if (j == k || m_sh_m[j])
                if (m_sh_d[4*j +: 4] != 4'h0 || m_sh_dp[j]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [17:0] expect_now();
        int         p    = int'(m_t % F);
        int         slot = p / SLOT;
        int         off  = p % SLOT;
        logic [7:0] an   = 8'hFF;
        logic [6:0] seg  = 7'h7F;
        logic       dp   = 1'b1;
        logic       fd   = (p == F - 1);
        if (off >= G && m_sh_m[slot] && !blanked(slot)) begin
            an       = 8'hFF;
            an[slot] = 1'b0;
            seg      = glyph(int'(m_sh_d[4*slot +: 4]));
            dp       = ~m_sh_dp[slot];
        end
        return {an, seg, dp, fd & m_pending, fd};
    endfunction

    task automatic model_clear();
        m_t = 0; m_pending = 1'b0;
        m_st_d = '0; m_st_dp = '0; m_st_m = '0;
        m_sh_d = '0; m_sh_dp = '0; m_sh_m = '0;
    endtask

    task automatic model_advance(input logic ld, input logic [31:0] d,
                                 input logic [7:0] dpv, input logic [7:0] m);
        if (int'(m_t % F) == F - 1 && m_pending) begin
            m_sh_d = m_st_d; m_sh_dp = m_st_dp; m_sh_m = m_st_m;
            m_pending = 1'b0;
        end
        if (ld) begin
            m_st_d = d; m_st_dp = dpv; m_st_m = m;
            m_pending = 1'b1;
        end
        m_t++;
    endtask

    task automatic check_cycle();
        chk("scan", 32'(expect_now()), 32'({an_o, seg_o, dp_o, load_ack_o, frame_done_o}));
    endtask

    // One clock of stimulus; inputs held through the next rising edge.
    task automatic step(input logic ld, input logic [31:0] d,
                        input logic [7:0] dpv, input logic [7:0] m);
        load_i = ld; data_i = d; dp_i = dpv; en_mask_i = m;
        model_advance(ld, d, dpv, m);
        @(posedge clk); #1;
        load_i = 1'b0;
        check_cycle();
    endtask

    task automatic step_idle();
        step(1'b0, $urandom, 8'($urandom), 8'($urandom));
    endtask

    task automatic apply_reset();
        reset_i = 1'b0;
        #1;
        chk("reset_async", 32'({an_o, seg_o, dp_o, load_ack_o, frame_done_o}),
            32'({8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0}));
        @(posedge clk); @(posedge clk); #1;
        chk("reset_hold", 32'({an_o, seg_o, dp_o, load_ack_o, frame_done_o}),
            32'({8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0}));
        model_clear();
        reset_i = 1'b1;
        check_cycle();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  mask;
        int          digit;
        logic [7:0]  an;
        logic [6:0]  seg;
        logic        dpo;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic [31:0] d, input logic [7:0] dpv, input logic [7:0] m,
                       input int dig, input logic [7:0] an, input logic [6:0] seg,
                       input logic dpo);
        vec_t v;
        v.data = d; v.dp = dpv; v.mask = m; v.digit = dig;
        v.an = an; v.seg = seg; v.dpo = dpo;
        vecs.push_back(v);
    endtask

    initial begin
        bit found;
        int cnt;
        int acks;

        add(32'h7654_3210, 8'h00, 8'hFF, 3, 8'hF7, 7'b0110000, 1'b1);
        add(32'h7654_3210, 8'h00, 8'hFF, 0, 8'hFE, 7'b1000000, 1'b1);
        add(32'h0000_00AB, 8'h00, 8'hFF, 0, 8'hFE, 7'b0000011, 1'b1);
        add(32'hFEDC_BA98, 8'h10, 8'hFF, 4, 8'hEF, 7'b1000110, 1'b0);
        add(32'h89AB_CDEF, 8'h00, 8'h05, 2, 8'hFB, 7'b0100001, 1'b1);
        add(32'h89AB_CDEF, 8'h00, 8'h05, 1, 8'hFF, 7'h7F,      1'b1);
        add(32'h1234_5678, 8'h80, 8'hFF, 7, 8'h7F, 7'b1111001, 1'b0);
        add(32'h89AB_CDEF, 8'h00, 8'hFF, 6, 8'hBF, 7'b0010000, 1'b1);
        add(32'h4E00_0000, 8'h00, 8'hFF, 6, 8'hBF, 7'b0000110, 1'b1);
        add(32'h4E00_0000, 8'h00, 8'hFF, 7, 8'h7F, 7'b0011001, 1'b1);
        add(32'h0000_0020, 8'h00, 8'hFF, 1, 8'hFD, 7'b0100100, 1'b1);
        add(32'h0050_0000, 8'h00, 8'hFF, 5, 8'hDF, 7'b0010010, 1'b1);
        add(32'h8600_0000, 8'h00, 8'hFF, 6, 8'hBF, 7'b0000010, 1'b1);
        add(32'h7000_0000, 8'h01, 8'hFF, 7, 8'h7F, 7'b1111000, 1'b1);
        add(32'h0A00_0000, 8'h00, 8'hFF, 6, 8'hBF, 7'b0001000, 1'b1);
        add(32'hF000_0000, 8'h00, 8'hFF, 7, 8'h7F, 7'b0001110, 1'b1);
        add(32'h0000_0120, 8'h00, 8'hFF, 2, 8'hFB, 7'b1111001, 1'b1);
        add(32'h0000_0000, 8'h00, 8'hFF, 0, 8'hFE, 7'b1000000, 1'b1);
        if (LZB) begin
            add(32'h0000_0120, 8'h00, 8'hFF, 4, 8'hFF, 7'h7F, 1'b1);
            add(32'h0000_0000, 8'h00, 8'hFF, 1, 8'hFF, 7'h7F, 1'b1);
        end else begin
            add(32'h0000_0120, 8'h00, 8'hFF, 4, 8'hEF, 7'b1000000, 1'b1);
            add(32'h0000_0000, 8'h00, 8'hFF, 1, 8'hFD, 7'b1000000, 1'b1);
        end

        reset_i = 1'b0; load_i = 1'b0;
        data_i = '0; dp_i = '0; en_mask_i = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        apply_reset();

        // Empty shadow mask: two frames with every anode off.
        for (int i = 0; i < 2 * F; i++) step_idle();

        foreach (vecs[r]) begin
            step(1'b1, vecs[r].data, vecs[r].dp, vecs[r].mask);
            found = 1'b0;
            for (int i = 0; i < 150 && !found; i++) begin
                if (load_ack_o === 1'b1) found = 1'b1;
                else step_idle();
            end
            chk("ack_wait", 32'(found), 32'd1);
            for (int i = 0; i < vecs[r].digit * SLOT + 4; i++) step_idle();
            chk("vec_digit", 32'({an_o, seg_o, dp_o}),
                32'({vecs[r].an, vecs[r].seg, vecs[r].dpo}));
            $display("row %0d: data=%h mask=%h digit %0d -> an=%h seg=%b dp=%b",
                     r, vecs[r].data, vecs[r].mask, vecs[r].digit, an_o, seg_o, dp_o);
        end

        // Load on a boundary cycle with nothing pending: ack one frame later.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (frame_done_o === 1'b1) found = 1'b1;
            else step_idle();
        end
        chk("boundary_wait", 32'(found), 32'd1);
        step(1'b1, 32'h0000_3A5C, 8'h02, 8'hFF);
        cnt = 1;
        while (load_ack_o !== 1'b1 && cnt < 100) begin
            step_idle();
            cnt++;
        end
        chk("boundary_load_latency", 32'(cnt), 32'd48);
        $display("boundary load: ack after %0d cycles", cnt);

        // Two loads in one frame yield a single acknowledge.
        repeat (3) step_idle();
        step(1'b1, 32'h1111_2222, 8'h00, 8'hFF);
        repeat (2) step_idle();
        step(1'b1, 32'hC0DE_9876, 8'h81, 8'hF3);
        acks = 0;
        for (int i = 0; i < 100; i++) begin
            step_idle();
            if (load_ack_o === 1'b1) acks++;
        end
        chk("double_load_acks", 32'(acks), 32'd1);
        $display("double load: %0d ack(s)", acks);

        // Reset while a load is pending discards it.
        repeat (10) step_idle();
        step(1'b1, 32'hDEAD_BEEF, 8'hFF, 8'hFF);
        repeat (5) step_idle();
        apply_reset();
        acks = 0;
        for (int i = 0; i < 120; i++) begin
            step_idle();
            if (load_ack_o === 1'b1) acks++;
        end
        chk("reset_discards_ack", 32'(acks), 32'd0);
        $display("reset mid-pending: %0d ack(s)", acks);

        // Randomised loads, checked every cycle against the model.
        for (int i = 0; i < 900; i++) begin
            step(($urandom_range(0, 19) == 0), $urandom, 8'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
